// File: rtl/lram_rom_pkg.sv
// lram_rom_pkg: shared widths, word type, default ROM contents and a
// word-extract helper for the lram_rom lookup table.
package lram_rom_pkg;

    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;

    typedef logic [DATA_W_DEF-1:0] rom_word_t;

    // word i = 8'h11 * i, word 0 in the least significant byte
    localparam logic [DEPTH_DEF*DATA_W_DEF-1:0] ROM_INIT =
        64'h7766_5544_3322_1100;

    function automatic rom_word_t rom_word(
        input logic [DEPTH_DEF*DATA_W_DEF-1:0] init,
        input int                              idx
    );
        return init[idx*DATA_W_DEF +: DATA_W_DEF];
    endfunction

endpackage

// File: rtl/lram_rom_array.sv
// lram_rom_array: combinational DEPTH x DATA_W lookup built from INIT,
// mapped to LUTs. Ports: addr (read address) -> data (word at addr).
module lram_rom_array
    import lram_rom_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter     INIT   = ROM_INIT
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    localparam int DEPTH = 2**ADDR_W;

    (* rom_style = "distributed", ram_style = "distributed" *)
    logic [DATA_W-1:0] rom [DEPTH];

    if ($bits(INIT) != DEPTH*DATA_W) begin : g_init_chk
        $error("lram_rom_array: INIT width must equal DEPTH*DATA_W");
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        if (DATA_W == DATA_W_DEF && DEPTH == DEPTH_DEF) begin : g_def
            assign rom[i] = rom_word(INIT, i);
        end else begin : g_gen
            assign rom[i] = INIT[i*DATA_W +: DATA_W];
        end
    end

    // DEPTH is 2**ADDR_W, so every address is in range
    assign data = rom[addr];

endmodule

// File: rtl/lram_rom.sv
// lram_rom: 8x8 LUT ROM with registered, async-cleared output.
// Ports: clock, reset (async, active-low), addr -> y (registered data).
// Define LRAM_ROM_OUT_PIPE_EN to add a second output register (latency 2).
module lram_rom
    import lram_rom_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter     INIT   = ROM_INIT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] y
);

    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] y_q;

    lram_rom_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .INIT   (INIT)
    ) u_array (
        .addr (addr),
        .data (rd)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            y_q <= '0;
        end else begin
            y_q <= rd;
        end
    end

`ifdef LRAM_ROM_OUT_PIPE_EN
    logic [DATA_W-1:0] y_p;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            y_p <= '0;
        end else begin
            y_p <= y_q;
        end
    end

    assign y = y_p;
`else
    assign y = y_q;
`endif

endmodule

// File: tb/tb_lram_rom.sv
// tb_lram_rom: directed self-checking bench for lram_rom, default
// contents plus an instance with overridden INIT.
module tb_lram_rom;

`ifdef LRAM_ROM_OUT_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clock;
    logic       reset;
    logic [2:0] addr;
    logic [7:0] y;
    logic [2:0] addr2;
    logic [7:0] y2;

    int checks;
    int passes;
    int since_rst;
    logic [2:0] hist [2];
    logic [7:0] exp_word [8];
    logic [7:0] e;

    lram_rom u_dut (
        .clock (clock),
        .reset (reset),
        .addr  (addr),
        .y     (y)
    );

    lram_rom #(
        .INIT (64'hF8F9_FAFB_FCFD_FEFF)
    ) u_inv (
        .clock (clock),
        .reset (reset),
        .addr  (addr2),
        .y     (y2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // drive addr, advance one rising edge, settle 1 time unit
    task automatic tick(input logic [2:0] a);
        addr = a;
        @(posedge clock);
        hist[1] = hist[0];
        hist[0] = a;
        if (reset) since_rst++;
        #1;
    endtask

    function automatic logic [7:0] expect_y();
        if (!reset || since_rst < LAT) return 8'h00;
        return exp_word[hist[LAT-1]];
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        addr  = 3'd0;
        addr2 = 3'd0;
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (y !== 8'h00)
            $display("FAIL reset_async y=%h expected=00", y);
        else passes++;
        for (int i = 0; i < 3; i++) begin
            tick(3'(i * 3 + 1));
            checks++;
            if (y !== 8'h00)
                $display("FAIL reset_hold%0d y=%h expected=00", i, y);
            else passes++;
        end
        @(negedge clock);
        reset = 1'b1;
        since_rst = 0;
    endtask

    task automatic test_count();
        for (int i = 0; i < 8; i++) begin
            tick(3'(i));
            e = expect_y();
            checks++;
            if (y !== e)
                $display("FAIL count a=%0d y=%h expected=%h", i, y, e);
            else passes++;
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 35; i++) begin
            tick(3'((i + 7) % 8));
            e = expect_y();
            checks++;
            if (y !== e)
                $display("FAIL wrap i=%0d y=%h expected=%h", i, y, e);
            else passes++;
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 4 + LAT - 1; i++) begin
            tick(3'd5);
            e = expect_y();
            checks++;
            if (y !== e)
                $display("FAIL hold i=%0d y=%h expected=%h", i, y, e);
            else passes++;
        end
        checks++;
        if (y !== 8'h55)
            $display("FAIL hold_final y=%h expected=55", y);
        else passes++;
    endtask

    task automatic test_midstream_reset();
        for (int i = 0; i < LAT; i++) tick(3'd4);
        checks++;
        if (y !== 8'h44)
            $display("FAIL mid_pre y=%h expected=44", y);
        else passes++;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (y !== 8'h00)
            $display("FAIL mid_async y=%h expected=00", y);
        else passes++;
        tick(3'd2);
        checks++;
        if (y !== 8'h00)
            $display("FAIL mid_hold y=%h expected=00", y);
        else passes++;
        @(negedge clock);
        reset = 1'b1;
        since_rst = 0;
        for (int i = 0; i < LAT; i++) begin
            tick(3'd6);
            e = (i == LAT - 1) ? 8'h66 : 8'h00;
            checks++;
            if (y !== e)
                $display("FAIL mid_resume%0d y=%h expected=%h", i, y, e);
            else passes++;
        end
    endtask

    task automatic test_init_override();
        logic [2:0] av [3];
        logic [7:0] ev [3];
        av = '{3'd0, 3'd7, 3'd3};
        ev = '{8'hFF, 8'hF8, 8'hFC};
        for (int k = 0; k < 3; k++) begin
            addr2 = av[k];
            for (int i = 0; i < 3; i++) tick(3'd0);
            checks++;
            if (y2 !== ev[k])
                $display("FAIL init a=%0d y=%h expected=%h",
                         av[k], y2, ev[k]);
            else passes++;
        end
    endtask

    initial begin
        checks    = 0;
        passes    = 0;
        since_rst = 0;
        hist[0]   = 3'd0;
        hist[1]   = 3'd0;
        exp_word  = '{8'h00, 8'h11, 8'h22, 8'h33,
                      8'h44, 8'h55, 8'h66, 8'h77};
        test_reset();
        test_count();
        test_wrap();
        test_hold();
        test_midstream_reset();
        test_init_override();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/lram_rom.md
Name: lram_rom

Overview:
- Small read-only lookup table: 3-bit address in, 8-bit data word out.
- Targets UltraScale LUT-based distributed memory (LUTRAM/LUT6 ROM), not block RAM.
- Synchronous read with a registered output, asynchronously cleared.
- Leaf block at the top of the primitives example; fed by an address counter, read out by the surrounding logic.

Parameters:
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W = 8 words.
- DATA_W, 8, data word width.
- INIT, lram_rom_pkg::ROM_INIT, packed DEPTH*DATA_W-bit contents; word i occupies bits [i*DATA_W +: DATA_W].

Ports:
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- addr   input  ADDR_W  read address, sampled every rising edge.
- y      output DATA_W  registered read data.

Behaviour:
- Default contents: word i = 8'h11 * i, i.e. 00,11,22,33,44,55,66,77 for addresses 0..7.
- Read path:
  - Combinational lookup ROM[addr] feeds the output register y_q; y = y_q.
  - Read latency is 1 cycle: y after edge k equals ROM[addr sampled at edge k].
- No enable; a read occurs every cycle. The same address on consecutive cycles returns the same word.
- Reset:
  - reset=0 clears y_q to 0 immediately, with no clock needed.
  - Reset is held while reset=0; addr is ignored during reset.
  - On deassertion (reset 0->1), the first rising edge loads ROM[addr]; y stays 0 until that edge.
  - Reset asserted mid-stream forces y=0 at once. Reads resume on the first edge after release; no stale data is retained.
- Addressing:
  - All 2**ADDR_W addresses are valid, so there is no out-of-range case.
  - Address wrap (7->0) needs no special handling.
- Contents are constant: no write port, and no contents change after configuration.
- Array must infer as distributed LUT ROM (ram_style/rom_style "distributed"), never BRAM.
- Width rules:
  - INIT width must equal DEPTH*DATA_W; a mismatch is an elaboration-time error.
  - y is zero-extended from nothing; it is exactly DATA_W bits.

Optional Feature:
- Macro LRAM_ROM_OUT_PIPE_EN.
- When defined:
  - A second output register is added after y_q; read latency becomes 2 cycles.
  - Both registers reset asynchronously to 0.
  - After reset release, y is 0 for the first 2 edges, then tracks ROM[addr from 2 edges earlier].
- When undefined: single register, latency 1, as above.
- Ports, contents and reset polarity are identical in both builds.

Decomposition:
- Package lram_rom_pkg holds:
  - ADDR_W_DEF=3, DATA_W_DEF=8, DEPTH_DEF=8.
  - typedef rom_word_t (logic [DATA_W_DEF-1:0]).
  - Constant ROM_INIT (the 8 default words packed).
  - Helper function rom_word(init, idx) that extracts word idx.
- One sub-module, lram_rom_array: purely combinational DEPTH x DATA_W lookup built from INIT. Mapped to LUTs; no clock and no reset.
- lram_rom itself holds the output register(s), reset logic and the optional pipeline stage.

Test Plan:
- Reset held 3 cycles with addr toggling -> y==8'h00 throughout; y goes 0 asynchronously at reset fall, without waiting for a clock edge.
- After release, addr counting 0,1,2,...,7 one per cycle -> y sequence 00,11,22,...,77, each value appearing one edge after its address (two with LRAM_ROM_OUT_PIPE_EN).
- addr wraps 7->0->1 over 35 cycles -> y repeats 77,00,11 continuously with no glitch or extra latency at the wrap.
- addr held at 5 for 4 cycles -> y==8'h55 stable every cycle.
- Reset pulsed low mid-sequence while y==8'h44 -> y==00 immediately; the first edge after release with addr=6 gives y==8'h66.
- Override INIT with word i = ~i (FF,FE,...,F8), then read addr=3 -> y==8'hFC.
